// File: rtl/detector_event_builder.sv
// Detector single-event builder: decodes timing/energy sample words, validates events and queues them in an output FIFO.
// Optional pileup rejection is enabled by defining PILEUP_REJECT_EN, which adds the npileup output.
module detector_event_builder #(
  parameter int unsigned SER_W     = 8,
  parameter int unsigned NTIME     = 2,
  parameter int unsigned NENERGY   = 8,
  parameter int unsigned E_BITS    = 12,
  parameter int unsigned CTR_BITS  = 17,
  parameter int unsigned ID_BITS   = 6,
  parameter int unsigned MAX_LEN   = 255,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned FT_BITS   = $clog2(SER_W),
  localparam int unsigned DATA_BITS = 6 + ID_BITS + NENERGY*E_BITS + CTR_BITS + FT_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_BITS-1:0]       block_id,
  input  logic [NTIME*SER_W-1:0]   time_data,
  input  logic [NENERGY*SER_W-1:0] energy_data,
  input  logic [CTR_BITS-1:0]      counter,
  input  logic                     period_done,
  input  logic                     data_ready,
  output logic                     data_valid,
  output logic [DATA_BITS-1:0]     data_out,
  output logic                     stall,
  output logic [47:0]              nsingles,
`ifdef PILEUP_REJECT_EN
  output logic [15:0]              npileup,
`endif
  output logic [15:0]              ndropped
);

  localparam int unsigned LEN_BITS = $clog2(MAX_LEN + 1);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned TS_BITS  = CTR_BITS + FT_BITS;

  typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_e;

  logic [NTIME-1:0]                trig_d, trig_q;
  logic [NENERGY-1:0]              full_d, full_q, active;
  logic                            act_any_d, act_any_q, start, finish;
  logic                            pulse;
  logic [FT_BITS-1:0]              pulse_fine;
  logic [NENERGY-1:0][E_BITS-1:0]  acc_d, acc_q;
  logic [E_BITS-1:0]               ebase;
  logic [E_BITS:0]                 esum;
  state_e                          state_d, state_q;
  logic [LEN_BITS-1:0]             len_d, len_q;
  logic                            tseen_d, tseen_q, aseen_d, aseen_q;
  logic                            pile_d, pile_q, etag_d, etag_q;
  logic [TS_BITS-1:0]              ts_d, ts_q;
  logic                            pend_d, pend_q, pend_tag_d, pend_tag_q;
  logic                            in_act, in_evt, ev_pulse, t_now, a_now, p_now, g_now;
  logic                            tag_set, evt_abort, evt_reject;
  logic [DEPTH-1:0][DATA_BITS-1:0] mem_d, mem_q;
  logic [DEPTH-1:0]                tagm_d, tagm_q;
  logic [AW:0]                     wptr_d, wptr_q, rptr_d, rptr_q;
  logic                            fifo_full, do_push, do_pop, do_drop;
  logic [DATA_BITS-1:0]            push_word, data_out_d, data_out_q;
  logic                            data_valid_d, data_valid_q, stall_d, stall_q;
  logic [47:0]                     nsingles_d, nsingles_q;
  logic [15:0]                     ndropped_d, ndropped_q;
`ifdef PILEUP_REJECT_EN
  logic [15:0]                     npileup_d, npileup_q;
`endif

  // Fine time of one word: bit SER_W-1 is earliest, so fine counts down from the highest set bit.
  function automatic logic [FT_BITS-1:0] ch_fine(input logic [SER_W-1:0] w);
    logic [FT_BITS-1:0] idx;
    idx = '0;
    for (int b = 0; b < SER_W; b++) if (w[b]) idx = FT_BITS'(b);
    return FT_BITS'(SER_W - 1) - idx;
  endfunction

  always_comb begin
    trig_d     = '0;
    full_d     = '0;
    pulse      = 1'b0;
    pulse_fine = '1;
    for (int i = 0; i < NTIME; i++) begin
      trig_d[i] = |time_data[i*SER_W +: SER_W];
      if (trig_d[i] && !trig_q[i]) begin
        pulse = 1'b1;
        if (ch_fine(time_data[i*SER_W +: SER_W]) < pulse_fine)
          pulse_fine = ch_fine(time_data[i*SER_W +: SER_W]);
      end
    end
    for (int j = 0; j < NENERGY; j++) full_d[j] = &energy_data[j*SER_W +: SER_W];
  end

  // Activity is stretched by one clk so start and finish never coincide.
  assign active    = full_d | full_q;
  assign act_any_d = |active;
  assign start     = act_any_d & ~act_any_q;
  assign finish    = ~act_any_d & act_any_q;

  always_comb begin
    acc_d = acc_q;
    ebase = '0;
    esum  = '0;
    for (int j = 0; j < NENERGY; j++) begin
      ebase    = start ? E_BITS'(0) : acc_q[j];
      esum     = (E_BITS+1)'(ebase) + (E_BITS+1)'($countones(energy_data[j*SER_W +: SER_W]));
      acc_d[j] = esum[E_BITS] ? '1 : esum[E_BITS-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    tseen_d    = tseen_q;
    aseen_d    = aseen_q;
    pile_d     = pile_q;
    etag_d     = etag_q;
    ts_d       = ts_q;
    pend_d     = 1'b0;
    pend_tag_d = 1'b0;
    evt_abort  = 1'b0;
    evt_reject = 1'b0;
    in_act     = (state_q == ACTIVE);
    in_evt     = in_act | ((state_q == IDLE) & start);
    ev_pulse   = in_evt & pulse;
    t_now      = (in_act & tseen_q) | ev_pulse;
    a_now      = (in_act & aseen_q) | (in_evt & (&active));
    p_now      = (in_act & pile_q) | (ev_pulse & in_act & tseen_q);
    tag_set    = in_evt & period_done & t_now & a_now;
    g_now      = (in_act & etag_q) | tag_set;
    if (ev_pulse && !(in_act && tseen_q)) ts_d = {counter, pulse_fine};
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          len_d   = LEN_BITS'(1);
          tseen_d = t_now;
          aseen_d = a_now;
          pile_d  = p_now;
          etag_d  = g_now;
        end
      end
      ACTIVE: begin
        tseen_d = t_now;
        aseen_d = a_now;
        pile_d  = p_now;
        etag_d  = g_now;
        if (finish) begin
          state_d = IDLE;
`ifdef PILEUP_REJECT_EN
          evt_reject = p_now;
`endif
          if (t_now && a_now && !evt_reject) begin
            pend_d     = 1'b1;
            pend_tag_d = g_now;
          end
        end else if (len_q == LEN_BITS'(MAX_LEN)) begin
          state_d   = ABORT;
          evt_abort = 1'b1;
        end else begin
          len_d = len_q + LEN_BITS'(1);
        end
      end
      ABORT: if (!act_any_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output FIFO, stall tracking and statistics.
  always_comb begin
    fifo_full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop    = (wptr_q != rptr_q) && data_ready;
    do_push   = pend_q && (!fifo_full || do_pop);
    do_drop   = pend_q && !do_push;
    push_word = {6'b111111, block_id, acc_q, ts_q};
    mem_d     = mem_q;
    tagm_d    = tagm_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]]  = push_word;
      tagm_d[wptr_q[AW-1:0]] = pend_tag_q;
      wptr_d                 = wptr_q + (AW+1)'(1);
    end
    if (do_pop) rptr_d = rptr_q + (AW+1)'(1);
    data_valid_d = (wptr_d != rptr_d);
    data_out_d   = (do_push && (rptr_d[AW-1:0] == wptr_q[AW-1:0])) ? push_word
                                                                  : mem_q[rptr_d[AW-1:0]];
    stall_d = stall_q;
    if (do_pop && tagm_q[rptr_q[AW-1:0]]) stall_d = 1'b0;
    if (do_drop && pend_tag_q) stall_d = 1'b0;
    if (tag_set) stall_d = 1'b1;
    if ((evt_abort || evt_reject) && g_now) stall_d = 1'b0;
    nsingles_d = nsingles_q + 48'(do_push);
    ndropped_d = (do_drop && (ndropped_q != 16'hFFFF)) ? ndropped_q + 16'd1 : ndropped_q;
`ifdef PILEUP_REJECT_EN
    npileup_d  = (evt_reject && (npileup_q != 16'hFFFF)) ? npileup_q + 16'd1 : npileup_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q       <= '0;
      full_q       <= '0;
      act_any_q    <= 1'b0;
      acc_q        <= '0;
      state_q      <= IDLE;
      len_q        <= '0;
      tseen_q      <= 1'b0;
      aseen_q      <= 1'b0;
      pile_q       <= 1'b0;
      etag_q       <= 1'b0;
      ts_q         <= '0;
      pend_q       <= 1'b0;
      pend_tag_q   <= 1'b0;
      mem_q        <= '0;
      tagm_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      nsingles_q   <= '0;
      ndropped_q   <= '0;
`ifdef PILEUP_REJECT_EN
      npileup_q    <= '0;
`endif
    end else begin
      trig_q       <= trig_d;
      full_q       <= full_d;
      act_any_q    <= act_any_d;
      acc_q        <= acc_d;
      state_q      <= state_d;
      len_q        <= len_d;
      tseen_q      <= tseen_d;
      aseen_q      <= aseen_d;
      pile_q       <= pile_d;
      etag_q       <= etag_d;
      ts_q         <= ts_d;
      pend_q       <= pend_d;
      pend_tag_q   <= pend_tag_d;
      mem_q        <= mem_d;
      tagm_q       <= tagm_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      stall_q      <= stall_d;
      nsingles_q   <= nsingles_d;
      ndropped_q   <= ndropped_d;
`ifdef PILEUP_REJECT_EN
      npileup_q    <= npileup_d;
`endif
    end
  end

  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;
  assign stall      = stall_q;
  assign nsingles   = nsingles_q;
  assign ndropped   = ndropped_q;
`ifdef PILEUP_REJECT_EN
  assign npileup    = npileup_q;
`endif

endmodule

// File: tb/tb_detector_event_builder.sv
// Directed self-checking bench for detector_event_builder at default parameters.
module tb_detector_event_builder;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   block_id;
  logic [15:0]  time_data;
  logic [63:0]  energy_data;
  logic [16:0]  counter;
  logic         period_done;
  logic         data_ready;
  logic         data_valid;
  logic [127:0] data_out;
  logic         stall;
  logic [47:0]  nsingles;
  logic [15:0]  ndropped;
`ifdef PILEUP_REJECT_EN
  logic [15:0]  npileup;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  detector_event_builder dut (
    .clk         (clk),
    .rst         (rst),
    .block_id    (block_id),
    .time_data   (time_data),
    .energy_data (energy_data),
    .counter     (counter),
    .period_done (period_done),
    .data_ready  (data_ready),
    .data_valid  (data_valid),
    .data_out    (data_out),
    .stall       (stall),
    .nsingles    (nsingles),
`ifdef PILEUP_REJECT_EN
    .npileup     (npileup),
`endif
    .ndropped    (ndropped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected normal end");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_word(input logic [5:0] bid, input logic [11:0] e,
                                           input logic [16:0] ctr, input logic [2:0] fine);
    return {6'h3F, bid, {8{e}}, ctr, fine};
  endfunction

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    counter = counter + 17'd1;
  endtask

  task automatic set_energy(input bit bad3, input bit on);
    for (int j = 0; j < 8; j++)
      energy_data[j*8 +: 8] = !on ? 8'h00 : ((bad3 && j == 3) ? 8'h7F : 8'hFF);
  endtask

  task automatic run_event(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                           input int nfull, input bit bad3, input int pd_cyc,
                           output logic [16:0] ctr0);
    ctr0 = counter;
    for (int c = 0; c < nfull; c++) begin
      time_data = '0;
      if (c == 0) time_data = {t1, t0};
      if (c == 2) time_data[7:0] = t2;
      period_done = (c == pd_cyc);
      set_energy(bad3, 1'b1);
      tick();
      if (c == pd_cyc) check_eq("stall_set", 128'(stall), 128'd1);
    end
    time_data   = '0;
    period_done = 1'b0;
    set_energy(1'b0, 1'b0);
    repeat (3) tick();
  endtask

  logic [16:0]  c0;
  logic [127:0] exp_q [6];
  logic [127:0] w2;
  bit           seen;

  initial begin
    rst = 1'b1; block_id = 6'h2A; time_data = '0; energy_data = '0;
    counter = 17'h1F000; period_done = 1'b0; data_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("rst_valid",    128'(data_valid), 128'd0);
    check_eq("rst_data",     data_out,         128'd0);
    check_eq("rst_stall",    128'(stall),      128'd0);
    check_eq("rst_nsingles", 128'(nsingles),   128'd0);
    check_eq("rst_ndropped", 128'(ndropped),   128'd0);

    // Basic event: ch0 8'h10, 3 full clks.
    run_event(8'h10, 8'h00, 8'h00, 3, 1'b0, -1, c0);
    check_eq("a_valid", 128'(data_valid), 128'd1);
    check_eq("a_word",  data_out, mk_word(6'h2A, 12'd24, c0, 3'd3));
    check_eq("a_nsing", 128'(nsingles), 128'd1);
    tick();
    check_eq("a_popped", 128'(data_valid), 128'd0);

    // Two channels rising together: earliest fine wins.
    run_event(8'h04, 8'h40, 8'h00, 4, 1'b0, -1, c0);
    check_eq("b_word",  data_out, mk_word(6'h2A, 12'd32, c0, 3'd1));
    check_eq("b_nsing", 128'(nsingles), 128'd2);
    tick();

    // Energy ch3 never full: event invalid.
    run_event(8'h10, 8'h00, 8'h00, 3, 1'b1, -1, c0);
    repeat (3) tick();
    check_eq("c_novalid", 128'(data_valid), 128'd0);
    check_eq("c_nsing",   128'(nsingles),   128'd2);

    // Overlong event aborts, then a normal event follows.
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      time_data = (c == 0) ? 16'h0010 : 16'h0000;
      set_energy(1'b0, 1'b1);
      tick();
      if (data_valid) seen = 1'b1;
    end
    time_data = '0;
    set_energy(1'b0, 1'b0);
    repeat (5) tick();
    check_eq("abort_nooutput", 128'(seen | data_valid), 128'd0);
    check_eq("abort_nsing",    128'(nsingles),          128'd2);
    run_event(8'h02, 8'h00, 8'h00, 2, 1'b0, -1, c0);
    check_eq("post_abort_word",  data_out, mk_word(6'h2A, 12'd16, c0, 3'd6));
    check_eq("post_abort_nsing", 128'(nsingles), 128'd3);
    tick();

    // Back-pressure: six events into a 4-deep FIFO.
    data_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      block_id = 6'(k + 1);
      run_event(8'h80, 8'h00, 8'h00, 3, 1'b0, -1, c0);
      exp_q[k] = mk_word(6'(k + 1), 12'd24, c0, 3'd0);
    end
    check_eq("bp_valid",    128'(data_valid), 128'd1);
    check_eq("bp_head",     data_out,         exp_q[0]);
    check_eq("bp_ndropped", 128'(ndropped),   128'd2);
    check_eq("bp_nsing",    128'(nsingles),   128'd7);
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_valid", 128'(data_valid), 128'd1);
      check_eq("drain_word",  data_out,         exp_q[k]);
      data_ready = 1'b1;
      tick();
    end
    check_eq("drain_empty", 128'(data_valid), 128'd0);

    // Stall tagging: held until the tagged word pops.
    check_eq("stall_idle", 128'(stall), 128'd0);
    data_ready = 1'b0;
    block_id   = 6'h15;
    run_event(8'h08, 8'h00, 8'h00, 3, 1'b0, 1, c0);
    check_eq("stall_hold", 128'(stall), 128'd1);
    check_eq("tag_word",   data_out, mk_word(6'h15, 12'd24, c0, 3'd4));
    run_event(8'h20, 8'h00, 8'h00, 3, 1'b0, -1, c0);
    w2 = mk_word(6'h15, 12'd24, c0, 3'd2);
    check_eq("stall_hold2", 128'(stall),    128'd1);
    check_eq("stall_nsing", 128'(nsingles), 128'd9);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check_eq("stall_clear", 128'(stall),      128'd0);
    check_eq("fifo_next",   data_out,         w2);
    check_eq("fifo_left",   128'(data_valid), 128'd1);

    // Reset asserted mid-event clears everything at once.
    time_data = 16'h0010; set_energy(1'b0, 1'b1);
    tick();
    time_data = '0; period_done = 1'b1;
    tick();
    period_done = 1'b0;
    check_eq("stall_set2", 128'(stall), 128'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid",    128'(data_valid), 128'd0);
    check_eq("mid_rst_data",     data_out,         128'd0);
    check_eq("mid_rst_stall",    128'(stall),      128'd0);
    check_eq("mid_rst_nsingles", 128'(nsingles),   128'd0);
    check_eq("mid_rst_ndropped", 128'(ndropped),   128'd0);
    set_energy(1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Second timing pulse inside the event.
    data_ready = 1'b1;
    block_id   = 6'h07;
    run_event(8'h10, 8'h00, 8'h01, 3, 1'b0, -1, c0);
`ifdef PILEUP_REJECT_EN
    check_eq("pileup_novalid", 128'(data_valid), 128'd0);
    check_eq("pileup_count",   128'(npileup),    128'd1);
    check_eq("pileup_nsing",   128'(nsingles),   128'd0);
`else
    check_eq("second_pulse_valid", 128'(data_valid), 128'd1);
    check_eq("second_pulse_word",  data_out, mk_word(6'h07, 12'd24, c0, 3'd3));
    check_eq("second_pulse_nsing", 128'(nsingles), 128'd1);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
